gen_a_param: RTL and testbench

Parametrised generator for the public polynomial "a". It loads a seed from the key byte RAM and hands it to the PRNG (Trivium) with a reseed handshake. It then rejection-samples little-endian SAMPLE_W-bit values from the PRNG output stream and writes N accepted coefficients into polynomial RAM. It sits between key RAM, the PRNG core and the NTT/multiply datapath. Compared with the fixed 512-point version it generalises N, word width, sample width and bound, and adds optional mod-Q reduction, busy status and a rejection counter.

---
 rtl/gen_a_pkg.sv | 25 ++
 rtl/gen_a_reduce.sv | 23 ++
 rtl/gen_a_param.sv | 167 ++++++++++++++++
 tb/tb_gen_a_param.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/gen_a_pkg.sv
// Shared constants, FSM encoding and helpers for the public-polynomial generator.
package gen_a_pkg;

    localparam int NH_Q        = 12289;
    localparam int NH_BOUND_5Q = 61445;
    localparam int NH_N_512    = 512;
    localparam int NH_N_1024   = 1024;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        LOAD_SEED = 3'd1,
        RESEED    = 3'd2,
        FETCH     = 3'd3,
        PARSE     = 3'd4
    } state_t;

    // Ceiling log2, never below 1 so it can size a port directly.
    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/gen_a_reduce.sv
// Combinational conditional-subtract reduction of an accepted sample into [0, Q).
module gen_a_reduce #(
    parameter int Q        = 12289,
    parameter int BOUND    = 61445,
    parameter int SAMPLE_W = 16
) (
    input  logic [SAMPLE_W-1:0] i_sample,
    output logic [SAMPLE_W-1:0] o_value
);

    localparam int M_MAX = (BOUND - 1) / Q;

    always_comb begin
        // NOTE: assign a default before any conditional write so no latch is inferred.
        o_value = i_sample;
        // Later (larger) multiples override earlier ones, leaving the largest m*Q <= sample.
        for (int m = 1; m <= M_MAX; m++) begin
            if (32'(i_sample) >= 32'(m * Q))
                o_value = SAMPLE_W'(32'(i_sample) - 32'(m * Q));
        end
    end

endmodule

// File: rtl/gen_a_param.sv
// Public polynomial "a" generator: seed load, PRNG reseed, rejection sampling into poly RAM.
module gen_a_param
    import gen_a_pkg::*;
#(
    parameter int N          = NH_N_512,
    parameter int WORD_W     = 128,
    parameter int SAMPLE_W   = 16,
    parameter int Q          = NH_Q,
    parameter int BOUND      = NH_BOUND_5Q,
    parameter int SEED_WORDS = 8,
    parameter int REDUCE     = 0
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start,
    output logic                          busy,
    output logic                          done,
    output logic [clog2(SEED_WORDS)-1:0]  seed_addr,
    input  logic [31:0]                   seed_do,
    output logic [32*SEED_WORDS-1:0]      seed,
    output logic                          reseed,
    input  logic                          reseed_ack,
    input  logic [WORD_W-1:0]             prng_data,
    input  logic                          prng_valid,
    output logic                          prng_ready,
    output logic                          poly_we,
    output logic [clog2(N)-1:0]           poly_addr,
    output logic [SAMPLE_W-1:0]           poly_di,
    output logic [15:0]                   rej_count
);

    localparam int ADDR_W  = clog2(N);
    localparam int SEED_AW = clog2(SEED_WORDS);
    localparam int SEED_CW = clog2(SEED_WORDS + 1);
    localparam int S       = WORD_W / SAMPLE_W;
    localparam int K_W     = clog2(S);
    localparam logic [SAMPLE_W:0] BOUND_W = (SAMPLE_W + 1)'(BOUND);

    state_t              r_state;
    logic [SEED_CW-1:0]  r_seed_cnt;
    logic [WORD_W-1:0]   r_word;
    logic [K_W-1:0]      r_k;
    logic [ADDR_W-1:0]   r_count;
    logic                r_done_pend;

    logic [SAMPLE_W-1:0] w_sample;
    logic [SAMPLE_W-1:0] w_value;
    logic [SEED_AW-1:0]  w_seed_idx;
    logic                w_accept;
    logic                w_last_k;
    logic                w_last_coef;

    assign w_sample    = r_word[r_k*SAMPLE_W +: SAMPLE_W];
    assign w_accept    = {1'b0, w_sample} < BOUND_W;
    assign w_last_k    = (r_k == K_W'(S - 1));
    assign w_last_coef = (r_count == ADDR_W'(N - 1));
    // Data on seed_do belongs to the address issued one cycle earlier.
    assign w_seed_idx  = SEED_AW'(r_seed_cnt - 1'b1);

    generate
        if (REDUCE != 0) begin : g_reduce
            gen_a_reduce #(
                .Q        (Q),
                .BOUND    (BOUND),
                .SAMPLE_W (SAMPLE_W)
            ) u_reduce (
                .i_sample (w_sample),
                .o_value  (w_value)
            );
        end else begin : g_raw
            assign w_value = w_sample;
        end
    endgenerate

    // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_seed_cnt  <= '0;
            r_word      <= '0;
            r_k         <= '0;
            r_count     <= '0;
            r_done_pend <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            seed_addr   <= '0;
            seed        <= '0;
            reseed      <= 1'b0;
            prng_ready  <= 1'b0;
            poly_we     <= 1'b0;
            poly_addr   <= '0;
            poly_di     <= '0;
            rej_count   <= '0;
        end else begin
            poly_we     <= 1'b0;
            done        <= r_done_pend;
            r_done_pend <= 1'b0;

            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_count    <= '0;
                        rej_count  <= '0;
                        r_seed_cnt <= '0;
                        seed_addr  <= '0;
                        busy       <= 1'b1;
                        r_state    <= LOAD_SEED;
                    end
                end

                LOAD_SEED: begin
                    if (r_seed_cnt != '0)
                        seed[32*w_seed_idx +: 32] <= seed_do;
                    if (r_seed_cnt == SEED_CW'(SEED_WORDS)) begin
                        reseed  <= 1'b1;
                        r_state <= RESEED;
                    end else begin
                        r_seed_cnt <= r_seed_cnt + 1'b1;
                        if (r_seed_cnt < SEED_CW'(SEED_WORDS - 1))
                            seed_addr <= seed_addr + 1'b1;
                    end
                end

                RESEED: begin
                    if (reseed_ack) begin
                        reseed     <= 1'b0;
                        prng_ready <= 1'b1;
                        r_state    <= FETCH;
                    end
                end

                FETCH: begin
                    if (prng_valid) begin
                        r_word     <= prng_data;
                        r_k        <= '0;
                        prng_ready <= 1'b0;
                        r_state    <= PARSE;
                    end
                end

                PARSE: begin
                    r_k <= r_k + 1'b1;
                    if (w_accept) begin
                        poly_we   <= 1'b1;
                        poly_addr <= r_count;
                        poly_di   <= w_value;
                        r_count   <= r_count + 1'b1;
                    end else if (rej_count != 16'hFFFF) begin
                        rej_count <= rej_count + 1'b1;
                    end
                    // The final coefficient wins over end-of-word; leftover samples are dropped.
                    if (w_accept && w_last_coef) begin
                        busy        <= 1'b0;
                        r_done_pend <= 1'b1;
                        r_state     <= IDLE;
                    end else if (w_last_k) begin
                        prng_ready <= 1'b1;
                        r_state    <= FETCH;
                    end
                end

                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_gen_a_param.sv
// Randomised bench for gen_a_param: raw and mod-Q instances run in lockstep against a sample-stream model.
module tb_gen_a_param;

    localparam int N     = 512;
    localparam int WW    = 128;
    localparam int SW    = 16;
    localparam int S     = WW / SW;
    localparam int Q     = 12289;
    localparam int BOUND = 61445;
    localparam int SEEDS = 8;
    localparam int NW    = 256;

    logic              clk = 1'b0;
    logic              rst, start, reseed_ack, prng_valid;
    logic [31:0]       seed_do;
    logic [WW-1:0]     prng_data;

    logic              busy0, done0, reseed0, ready0, we0;
    logic              busy1, done1, reseed1, ready1, we1;
    logic [2:0]        seed_addr0, seed_addr1;
    logic [32*SEEDS-1:0] seed0, seed1;
    logic [8:0]        paddr0, paddr1;
    logic [SW-1:0]     pdi0, pdi1;
    logic [15:0]       rej0, rej1;

    logic [31:0]       seed_mem [SEEDS];
    logic [WW-1:0]     words [NW];

    int n_checks = 0;
    int n_pass   = 0;

    int got_addr[$];
    int got_raw[$];
    int got_red[$];
    int ref_raw[$];

    always #5 clk = ~clk;

    always @(posedge clk) seed_do <= seed_mem[seed_addr0];

    gen_a_param #(.REDUCE(0)) dut0 (
        .clk(clk), .rst(rst), .start(start), .busy(busy0), .done(done0),
        .seed_addr(seed_addr0), .seed_do(seed_do), .seed(seed0),
        .reseed(reseed0), .reseed_ack(reseed_ack),
        .prng_data(prng_data), .prng_valid(prng_valid), .prng_ready(ready0),
        .poly_we(we0), .poly_addr(paddr0), .poly_di(pdi0), .rej_count(rej0)
    );

    gen_a_param #(.REDUCE(1)) dut1 (
        .clk(clk), .rst(rst), .start(start), .busy(busy1), .done(done1),
        .seed_addr(seed_addr1), .seed_do(seed_do), .seed(seed1),
        .reseed(reseed1), .reseed_ack(reseed_ack),
        .prng_data(prng_data), .prng_valid(prng_valid), .prng_ready(ready1),
        .poly_we(we1), .poly_addr(paddr1), .poly_di(pdi1), .rej_count(rej1)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // mode 0: all ones, 1: alternating 61444/61445, 2: random mix incl. boundaries
    task automatic fill_words(input int mode);
        logic [WW-1:0] w;
        logic [SW-1:0] s;
        for (int i = 0; i < NW; i++) begin
            for (int k = 0; k < S; k++) begin
                case (mode)
                    0: s = 16'd1;
                    1: s = (k % 2 == 0) ? 16'd61444 : 16'd61445;
                    default: begin
                        case ($urandom_range(7))
                            0: s = 16'd0;
                            1: s = 16'd12288;
                            2: s = 16'd12289;
                            3: s = 16'd24578;
                            4: s = 16'd61444;
                            5: s = 16'd61445;
                            6: s = 16'd65535;
                            default: s = 16'($urandom_range(65535));
                        endcase
                    end
                endcase
                w[k*SW +: SW] = s;
            end
            words[i] = w;
        end
    endtask

    task automatic fill_seed(input bit pattern);
        for (int i = 0; i < SEEDS; i++)
            seed_mem[i] = pattern ? (32'hA5A5_0000 + i) : $urandom;
    endtask

    task automatic run(input string name, input int stall_pct, input int ack_delay, input int reset_at);
        int widx, dones, done_cyc, we_last, rs_hi, bad_ready, cyc;
        int exp_vals[$];
        int exp_rej, exp_words;
        bit prev_rs, ready_at_fall, finished;
        logic [SW-1:0] s;

        got_addr.delete(); got_raw.delete(); got_red.delete();
        widx = 0; dones = 0; done_cyc = -1; we_last = -1; rs_hi = 0; bad_ready = 0;
        prev_rs = 0; ready_at_fall = 0; finished = 0;

        @(negedge clk);
        start = 1'b1;
        for (cyc = 0; cyc < 20000 && !finished; cyc++) begin
            @(negedge clk);
            start = busy0 ? ($urandom_range(3) == 0) : 1'b0;
            if (we0) begin
                got_addr.push_back(int'(paddr0));
                got_raw.push_back(int'(pdi0));
                got_red.push_back(int'(pdi1));
                we_last = cyc;
            end
            if (done0) begin
                dones++;
                done_cyc = cyc;
            end
            if (ready0 && (reseed0 || !busy0)) bad_ready++;
            if (reseed0) rs_hi++;
            if (prev_rs && !reseed0) ready_at_fall = ready0;
            prev_rs = reseed0;
            reseed_ack = reseed0 ? (rs_hi > ack_delay) : 1'($urandom_range(1));

            prng_valid = ($urandom_range(99) >= stall_pct);
            prng_data  = words[widx];
            if (prng_valid && ready0) begin
                widx++;
                if (widx >= NW) begin
                    $display("FAIL %s_words: word supply exhausted at %0d", name, widx);
                    $fatal(1, "word supply exhausted");
                end
            end

            if (reset_at > 0 && got_addr.size() >= reset_at) begin
                start = 1'b0; prng_valid = 1'b0; reseed_ack = 1'b0;
                rst = 1'b1;
                @(negedge clk);
                @(negedge clk);
                rst = 1'b0;
                check({name, "_rst_done_seen"}, dones, 0);
                check({name, "_rst_busy"}, busy0, 0);
                check({name, "_rst_rej"}, rej0, 0);
                check({name, "_rst_ready"}, ready0, 0);
                check({name, "_rst_we_done"}, {we0, done0}, 0);
                repeat (4) begin
                    @(negedge clk);
                    if (done0) dones++;
                end
                check({name, "_no_late_done"}, dones, 0);
                return;
            end
            if (dones > 0 && cyc >= done_cyc + 4) finished = 1;
        end
        start = 1'b0; prng_valid = 1'b0; reseed_ack = 1'b0;

        // Reference: walk the consumed sample stream, keeping samples below BOUND until N are held.
        exp_vals.delete(); exp_rej = 0; exp_words = 0;
        for (int w = 0; w < NW && exp_vals.size() < N; w++) begin
            exp_words++;
            for (int k = 0; k < S && exp_vals.size() < N; k++) begin
                s = words[w][k*SW +: SW];
                if (int'(s) < BOUND) exp_vals.push_back(int'(s));
                else exp_rej++;
            end
        end

        check({name, "_done_count"}, dones, 1);
        check({name, "_done_after_we"}, done_cyc, we_last + 1);
        check({name, "_writes"}, got_addr.size(), N);
        for (int i = 0; i < N && i < got_addr.size(); i++) begin
            check($sformatf("%s_wr%0d", name, i), {got_addr[i], got_raw[i]}, {i, exp_vals[i]});
            check($sformatf("%s_red%0d", name, i), got_red[i], exp_vals[i] % Q);
        end
        check({name, "_rej"}, rej0, exp_rej);
        check({name, "_rej_red"}, rej1, exp_rej);
        check({name, "_words_used"}, widx, exp_words);
        check({name, "_reseed_len"}, rs_hi, ack_delay + 1);
        check({name, "_ready_after_ack"}, ready_at_fall, 1);
        check({name, "_ready_outside_fetch"}, bad_ready, 0);
        check({name, "_busy_end"}, busy0, 0);
        for (int i = 0; i < SEEDS; i++)
            check($sformatf("%s_seed%0d", name, i), seed0[32*i +: 32], seed_mem[i]);
        repeat (3) @(negedge clk);
        check({name, "_rej_hold"}, rej0, exp_rej);
        check({name, "_addr_hold"}, paddr0, N - 1);
    endtask

    initial begin
        int mism;
        rst = 1'b1; start = 1'b0; reseed_ack = 1'b0; prng_valid = 1'b0; prng_data = '0;
        fill_seed(1'b1);
        fill_words(0);
        repeat (3) @(negedge clk);
        check("reset_busy_done", {busy0, done0}, 0);
        check("reset_seed", seed0[63:0], 0);
        check("reset_hs", {reseed0, ready0, we0}, 0);
        check("reset_addr_rej", {paddr0, rej0}, 0);
        rst = 1'b0;
        @(negedge clk);

        run("accept_all", 0, 5, 0);
        check("accept_all_words", 64, got_addr.size() / S);

        fill_seed(1'b0);
        fill_words(1);
        run("boundary", 0, 0, 0);

        fill_seed(1'b0);
        fill_words(2);
        run("random", 0, 2, 0);
        ref_raw = got_raw;

        run("stall", 50, 3, 0);
        mism = 0;
        for (int i = 0; i < N; i++)
            if (i >= got_raw.size() || i >= ref_raw.size() || got_raw[i] != ref_raw[i]) mism++;
        check("stall_vs_nostall", mism, 0);

        fill_seed(1'b0);
        fill_words(2);
        run("abort", 20, 1, 200);
        run("restart", 10, 4, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
